// File: rtl/clk_div_cfg_pkg.sv
// Shared types and default constants for the divider reconfiguration controller.
// The optional settle timeout is enabled by defining CLK_DIV_CFG_TIMEOUT_EN.
package clk_div_cfg_pkg;

    // Controller states: IDLE accepts requests, GATE holds the clock enable low,
    // LOAD presents the new divisor, SETTLE waits for the divider to lock.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } cfg_state_e;

    localparam int unsigned DIV_VALUE_WIDTH_DEF = 32'd32;
    localparam int unsigned DEF_DIV_DEF         = 32'd2;
    localparam int unsigned GATE_CYCLES_DEF     = 32'd2;
    localparam int unsigned TIMEOUT_CYCLES_DEF  = 32'd1024;

endpackage

// File: rtl/clk_div_cfg_tmo.sv
// Settle-timeout counter for clk_div_cfg_ctrl. Counts consecutive cycles in
// which the controller is waiting for the divider; reports the cycle that
// reaches TIMEOUT_CYCLES. Only instantiated when CLK_DIV_CFG_TIMEOUT_EN is defined.
module clk_div_cfg_tmo
    import clk_div_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    logic [CNT_W-1:0] cnt_r;
    logic             hit_s;

    // Flag the waiting cycle that completes the timeout window.
    always_comb begin
        hit_s = 1'b0;
        if (run && (cnt_r == CNT_LAST_C)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Count waiting cycles; restart whenever waiting stops or the window expires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (run && !hit_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign expired = hit_s;

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Divider reconfiguration controller: accepts an even divisor request, gates
// the downstream clock, hands the registered divisor to the divider and
// re-enables the clock once the divider reports a stable output.
// Optional feature macro: CLK_DIV_CFG_TIMEOUT_EN (settle timeout, sticky timeout_o).
module clk_div_cfg_ctrl
    import clk_div_cfg_pkg::*;
#(
    parameter int unsigned DIV_VALUE_WIDTH = DIV_VALUE_WIDTH_DEF,
    parameter int unsigned DEF_DIV         = DEF_DIV_DEF,
    parameter int unsigned GATE_CYCLES     = GATE_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [DIV_VALUE_WIDTH-1:0] req_div_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    output logic [DIV_VALUE_WIDTH-1:0] div_o,
    output logic                       div_valid_o,
    input  logic                       div_ready_i,
    input  logic                       div_done_i,
    output logic                       clk_en_o,
    output logic                       cfg_done_o,
    output logic                       err_o,
    output logic                       timeout_o
);

    localparam logic [DIV_VALUE_WIDTH-1:0] MIN_DIV_C = DIV_VALUE_WIDTH'(2);
    localparam logic [DIV_VALUE_WIDTH-1:0] DEF_DIV_C = DIV_VALUE_WIDTH'(DEF_DIV);
    localparam int unsigned GATE_CNT_W = (GATE_CYCLES > 32'd1) ? $clog2(GATE_CYCLES) : 32'd1;
    localparam logic [GATE_CNT_W-1:0] GATE_LAST_C = GATE_CNT_W'(GATE_CYCLES - 32'd1);

    // The downstream divider only supports even ratios of two or more.
    function automatic logic div_is_legal(input logic [DIV_VALUE_WIDTH-1:0] value);
        div_is_legal = (value >= MIN_DIV_C) && (value[0] == 1'b0);
    endfunction

    cfg_state_e                 state_r;
    logic [DIV_VALUE_WIDTH-1:0] div_r;
    logic [DIV_VALUE_WIDTH-1:0] pend_r;
    logic [GATE_CNT_W-1:0]      gate_cnt_r;
    logic                       div_valid_r;
    logic                       clk_en_r;
    logic                       cfg_done_r;
    logic                       err_r;
    logic                       req_ready_s;

    // Requests are only accepted while idle; anything else stalls the requester.
    always_comb begin
        req_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            req_ready_s = 1'b1;
        end else begin
            req_ready_s = 1'b0;
        end
    end

`ifdef CLK_DIV_CFG_TIMEOUT_EN
    logic tmo_run_s;
    logic tmo_hit_s;
    logic timeout_r;

    // The timeout window runs only while waiting for a lock that has not arrived.
    always_comb begin
        tmo_run_s = 1'b0;
        if ((state_r == ST_SETTLE) && !div_done_i) begin
            tmo_run_s = 1'b1;
        end else begin
            tmo_run_s = 1'b0;
        end
    end

    clk_div_cfg_tmo #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .run     (tmo_run_s),
        .expired (tmo_hit_s)
    );

    assign timeout_o = timeout_r;
`else
    assign timeout_o = 1'b0;
`endif

    // Reconfiguration sequencer; every output it drives is a flop.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_SETTLE;
            div_r       <= DEF_DIV_C;
            pend_r      <= DEF_DIV_C;
            gate_cnt_r  <= {GATE_CNT_W{1'b0}};
            div_valid_r <= 1'b0;
            clk_en_r    <= 1'b0;
            cfg_done_r  <= 1'b0;
            err_r       <= 1'b0;
`ifdef CLK_DIV_CFG_TIMEOUT_EN
            timeout_r   <= 1'b0;
`endif
        end else begin
            cfg_done_r <= 1'b0;
            err_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        if (!div_is_legal(req_div_i)) begin
                            err_r <= 1'b1;
                        end else if (req_div_i == div_r) begin
                            // Already running at this ratio: nothing to reload.
                            cfg_done_r <= 1'b1;
                        end else begin
                            pend_r     <= req_div_i;
                            clk_en_r   <= 1'b0;
                            gate_cnt_r <= {GATE_CNT_W{1'b0}};
                            state_r    <= ST_GATE;
`ifdef CLK_DIV_CFG_TIMEOUT_EN
                            timeout_r  <= 1'b0;
`endif
                        end
                    end
                end
                ST_GATE: begin
                    if (gate_cnt_r == GATE_LAST_C) begin
                        div_r       <= pend_r;
                        div_valid_r <= 1'b1;
                        state_r     <= ST_LOAD;
                    end else begin
                        gate_cnt_r <= gate_cnt_r + GATE_CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (div_ready_i) begin
                        div_valid_r <= 1'b0;
                        state_r     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (div_done_i) begin
                        clk_en_r   <= 1'b1;
                        cfg_done_r <= 1'b1;
                        state_r    <= ST_IDLE;
`ifdef CLK_DIV_CFG_TIMEOUT_EN
                    end else if (tmo_hit_s) begin
                        // Give up: leave the clock gated and report it.
                        timeout_r <= 1'b1;
                        state_r   <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    div_valid_r <= 1'b0;
                    clk_en_r    <= 1'b0;
                    state_r     <= ST_SETTLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_s;
    assign div_o       = div_r;
    assign div_valid_o = div_valid_r;
    assign clk_en_o    = clk_en_r;
    assign cfg_done_o  = cfg_done_r;
    assign err_o       = err_r;

endmodule

// File: doc/clk_div_cfg_ctrl.md
CLK_DIV_CFG_CTRL -- requirements
Module: clk_div_cfg_ctrl

Interface
REQ-001 Parameter DIV_VALUE_WIDTH, default 32: width of every divisor bus.
REQ-002 Parameter DEF_DIV, default 2: divisor driven after reset; even and at least 2.
REQ-003 Parameter GATE_CYCLES, default 2: cycles the clock enable stays low before a new divisor is loaded.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: settle-timeout limit; used only when CLK_DIV_CFG_TIMEOUT_EN is defined.
REQ-005 clk_i  in  1  sole clock for all state.
REQ-006 rst_n_i  in  1  reset, synchronous and active-low.
REQ-007 req_div_i  in  DIV_VALUE_WIDTH  requested divisor.
REQ-008 req_valid_i  in  1  requester offers req_div_i.
REQ-009 req_ready_o  out  1  block accepts a request.
REQ-010 div_o  out  DIV_VALUE_WIDTH  registered divisor sent to the downstream even divider.
REQ-011 div_valid_o  out  1  divisor update strobe to the divider.
REQ-012 div_ready_i  in  1  divider accepts the update.
REQ-013 div_done_i  in  1  divider reports a stable output clock.
REQ-014 clk_en_o  out  1  enable for the downstream gate on the divided clock.
REQ-015 cfg_done_o  out  1  one-cycle pulse when a reconfiguration completes.
REQ-016 err_o  out  1  one-cycle pulse when a request is rejected.
REQ-017 timeout_o  out  1  sticky flag: the divider failed to settle.

Function
REQ-018 The FSM SHALL have the states IDLE, GATE, LOAD and SETTLE.
REQ-019 req_ready_o SHALL be 1 only in IDLE; it is a combinational decode of the state.
REQ-020 A handshake is req_valid_i & req_ready_o.
- On handshake with req_div_i < 2 or odd: err_o pulses the next cycle, no other state changes, and the FSM remains in IDLE.
REQ-021 On a valid handshake with req_div_i == div_o: cfg_done_o pulses the next cycle, with no gating and no divider handshake.
REQ-022 On any other valid handshake:
- capture req_div_i into a pending register;
- clear timeout_o;
- drive clk_en_o to 0;
- enter GATE.
REQ-023 GATE SHALL last exactly GATE_CYCLES cycles with clk_en_o at 0, then enter LOAD.
REQ-024 On entry to LOAD, div_o SHALL take the pending value and div_valid_o SHALL rise.
- div_valid_o and div_o hold stable until div_ready_i is 1.
- In the div_ready_i cycle, div_valid_o drops next cycle and the FSM enters SETTLE.
REQ-025 div_o SHALL change only on entry to LOAD or on reset, so the divider always sees a registered divisor.
REQ-026 In SETTLE, the first cycle with div_done_i at 1 SHALL:
- set clk_en_o to 1;
- pulse cfg_done_o;
- return the FSM to IDLE.
Total latency from handshake to cfg_done_o = 1 + GATE_CYCLES + (LOAD cycles) + (SETTLE cycles).
REQ-027 req_valid_i asserted outside IDLE SHALL be stalled (ready low) and never dropped or reordered.
REQ-028 div_done_i SHALL be ignored outside SETTLE.

Reset
REQ-029 While rst_n_i is 0 at a clk_i edge, the block SHALL reset as follows:
- state = SETTLE;
- div_o = DEF_DIV;
- div_valid_o = 0, clk_en_o = 0, cfg_done_o = 0, err_o = 0, timeout_o = 0;
- timeout counter = 0.
REQ-030 Reset asserted mid-operation SHALL abandon any pending divisor and any in-flight divider handshake.
REQ-031 The first div_done_i after reset SHALL enable the clock and pulse cfg_done_o.

Configuration
REQ-032 With CLK_DIV_CFG_TIMEOUT_EN defined:
- SETTLE counts cycles;
- on reaching TIMEOUT_CYCLES without div_done_i, set timeout_o, keep clk_en_o at 0, enter IDLE, and give no cfg_done_o;
- timeout_o clears on the next accepted valid request.
REQ-033 Without CLK_DIV_CFG_TIMEOUT_EN: SETTLE waits indefinitely, timeout_o is tied to 0, and no counter is built.

Structure
REQ-034 Package clk_div_cfg_pkg SHALL hold:
- the FSM state enum;
- default constants for DIV_VALUE_WIDTH, DEF_DIV, GATE_CYCLES and TIMEOUT_CYCLES.
REQ-035 One sub-module, clk_div_cfg_tmo, SHALL hold the settle-timeout counter; it is instantiated only under CLK_DIV_CFG_TIMEOUT_EN.
REQ-036 All state SHALL be in synchronously reset flops clocked by clk_i.

Verification
REQ-037 Reset release with div_done_i rising 5 cycles later -> div_o=2, clk_en_o rises, and cfg_done_o pulses once.
REQ-038 req_div_i=8 accepted, div_ready_i held 0 for 3 cycles, div_done_i 4 cycles later -> clk_en_o low for the whole sequence, div_o=8 stable while valid is high, and one cfg_done_o.
REQ-039 req_div_i=7, then 0 -> two err_o pulses, div_o unchanged, and clk_en_o stays 1.
REQ-040 req_div_i equal to the current div_o -> cfg_done_o the next cycle, and div_valid_o never asserts.
REQ-041 New request offered during GATE -> req_ready_o low; the request is accepted only after cfg_done_o.
REQ-042 With the macro defined, TIMEOUT_CYCLES=16 and div_done_i held 0 -> timeout_o set after 16 SETTLE cycles; the next valid request clears it.
